// File: rtl/plru_state_engine.sv
// plru_state_engine
//   Owns the tree-PLRU replacement state for every set of the LLC and
//   applies one request at a time (TOUCH / VICTIM / FILL / CLEAR) to the
//   addressed set. Each request walks IDLE -> CALC -> RESP, producing exactly
//   one registered response.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req_valid/ready   request handshake (accepted when both are high)
//   req_op            00 TOUCH, 01 VICTIM, 10 FILL, 11 CLEAR
//   req_set           target set index
//   req_way           accessed way (TOUCH only)
//   resp_valid/ready  response handshake
//   resp_way          touched way, victim way, or 0 for CLEAR
//   resp_op           opcode of the request being answered
module plru_state_engine #(
    parameter int N_WAY = 16,
    parameter int N_SET = 64,
    parameter int WAY_W = $clog2(N_WAY),
    parameter int SET_W = $clog2(N_SET)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAY_W-1:0] req_way,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WAY_W-1:0] resp_way,
    output logic [1:0]       resp_op
);

    localparam int NODES = N_WAY - 1;

    localparam logic [1:0] OP_TOUCH  = 2'b00;
    localparam logic [1:0] OP_VICTIM = 2'b01;
    localparam logic [1:0] OP_FILL   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    // Node 0 is the root; children of node n are 2n+1 (way bit 0) and 2n+2.
    logic [NODES-1:0] plru_mem [N_SET];

    logic [1:0]       op_p0;
    logic [SET_W-1:0] set_p0;
    logic [WAY_W-1:0] way_p0;

    logic [NODES-1:0] cur_bits;
    logic [NODES-1:0] nxt_bits;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] resp_way_nxt;

    // Follow the side each node bit does NOT point to; bits point toward MRU.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
        logic [WAY_W-1:0] v;
        int               node;
        v    = '0;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            v[WAY_W-1-lvl] = ~bits[node];
            node = 2 * node + 1 + (bits[node] ? 0 : 1);
        end
        return v;
    endfunction

    // Point every node on way w's path toward w; other nodes keep their value.
    function automatic logic [NODES-1:0] plru_update(input logic [NODES-1:0] bits,
                                                     input logic [WAY_W-1:0] w);
        logic [NODES-1:0] b;
        int               node;
        b    = bits;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b[node] = w[WAY_W-1-lvl];
            node = 2 * node + 1 + (w[WAY_W-1-lvl] ? 1 : 0);
        end
        return b;
    endfunction

    // ---- stage p0: request latched at acceptance ----
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            op_p0  <= req_op;
            set_p0 <= req_set;
            way_p0 <= req_way;
        end
    end

    // ---- CALC: read-modify of the latched set ----
    always_comb begin
        cur_bits     = plru_mem[set_p0];
        victim       = plru_victim(cur_bits);
        nxt_bits     = cur_bits;
        resp_way_nxt = victim;
        case (op_p0)
            OP_TOUCH: begin
                nxt_bits     = plru_update(cur_bits, way_p0);
                resp_way_nxt = way_p0;
            end
            OP_VICTIM: begin
                nxt_bits = cur_bits;
            end
            OP_FILL: begin
                // Victim comes from the pre-update bits, then becomes MRU.
                nxt_bits = plru_update(cur_bits, victim);
            end
            default: begin
                nxt_bits     = '0;
                resp_way_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_SET; s++) begin
                plru_mem[s] <= '0;
            end
        end else if (state == CALC) begin
            plru_mem[set_p0] <= nxt_bits;
        end
    end

    // ---- RESP: registered response, held until consumed ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_way <= '0;
            resp_op  <= '0;
        end else if (state == CALC) begin
            resp_way <= resp_way_nxt;
            resp_op  <= op_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
